// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipelined core: reset PC, NOP encoding,
// fetch FSM state encoding and a PC increment helper.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^32 without any exception
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; anything else
// becomes a bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            valid
);

    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pcplus4_r;
    logic            valid_r;

    // Decode-side register; PC fields hold on flush and on bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_r   <= NOP_INSTR;
            pc_r      <= 32'h0000_0000;
            pcplus4_r <= 32'h0000_0000;
            valid_r   <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end else if (stall) begin
            valid_r <= valid_r;
        end else if (load) begin
            instr_r   <= instr_in;
            pc_r      <= pc_in;
            pcplus4_r <= pcplus4_in;
            valid_r   <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign instr   = instr_r;
    assign pc      = pc_r;
    assign pcplus4 = pcplus4_r;
    assign valid   = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding req/gnt/rvalid
// fetch FSM with a one-entry skid buffer, feeding the IF/ID register.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [XLEN-1:0] pcf_r;
    logic [XLEN-1:0] pcf_nxt_s;
    logic [XLEN-1:0] pcplus4f_s;
    logic [XLEN-1:0] skid_r;
    logic [XLEN-1:0] skid_nxt_s;
    logic [XLEN-1:0] load_instr_s;
    logic            kill_r;
    logic            kill_nxt_s;
    logic            load_s;
    logic            imem_req_s;
    fetch_state_e    resume_s;

    assign pcplus4f_s = pc_plus4(pcf_r);

    // State, PC, kill flag and skid buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            pcf_r   <= RESET_PC;
            kill_r  <= 1'b0;
            skid_r  <= NOP_INSTR;
        end else begin
            state_r <= state_nxt_s;
            pcf_r   <= pcf_nxt_s;
            kill_r  <= kill_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

    // Next-state logic; a redirect always wins the PC and drops in-flight data
    always_comb begin
        state_nxt_s  = state_r;
        pcf_nxt_s    = pcf_r;
        kill_nxt_s   = kill_r;
        skid_nxt_s   = skid_r;
        load_s       = 1'b0;
        load_instr_s = imem_rdata;
        if (StallF) begin
            resume_s = S_IDLE;
        end else begin
            resume_s = S_REQ;
        end
        case (state_r)
            S_IDLE: begin
                if (PCSrcE) begin
                    pcf_nxt_s = PCTargetE;
                end else begin
                    pcf_nxt_s = pcf_r;
                end
                state_nxt_s = resume_s;
            end
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_nxt_s = PCTargetE;
                    // A grant racing the redirect belongs to the old path
                    if (imem_gnt) begin
                        kill_nxt_s  = 1'b1;
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else if (imem_gnt) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (!imem_rvalid) begin
                    if (PCSrcE) begin
                        pcf_nxt_s  = PCTargetE;
                        kill_nxt_s = 1'b1;
                    end else begin
                        kill_nxt_s = kill_r;
                    end
                end else if (kill_r || PCSrcE) begin
                    if (PCSrcE) begin
                        pcf_nxt_s = PCTargetE;
                    end else begin
                        pcf_nxt_s = pcf_r;
                    end
                    kill_nxt_s  = 1'b0;
                    state_nxt_s = S_REQ;
                end else if (!StallD || FlushD) begin
                    load_s      = 1'b1;
                    pcf_nxt_s   = pcplus4f_s;
                    state_nxt_s = resume_s;
                end else begin
                    skid_nxt_s  = imem_rdata;
                    state_nxt_s = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_nxt_s   = PCTargetE;
                    state_nxt_s = S_REQ;
                end else if (!StallD || FlushD) begin
                    load_s       = 1'b1;
                    load_instr_s = skid_r;
                    pcf_nxt_s    = pcplus4f_s;
                    state_nxt_s  = resume_s;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                kill_nxt_s  = 1'b0;
            end
        endcase
    end

    // Request is a pure decode of the state
    always_comb begin
        imem_req_s = 1'b0;
        if (state_r == S_REQ) begin
            imem_req_s = 1'b1;
        end else begin
            imem_req_s = 1'b0;
        end
    end

    assign imem_req  = imem_req_s;
    assign imem_addr = pcf_r;
    assign PCF       = pcf_r;

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (StallD),
        .flush     (FlushD),
        .load      (load_s),
        .instr_in  (load_instr_s),
        .pc_in     (pcf_r),
        .pcplus4_in(pcplus4f_s),
        .instr     (InstrD),
        .pc        (PCD),
        .pcplus4   (PCPlus4D),
        .valid     (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table, directed corner sequences
// and a randomized run against a stream-level model of the fetch path.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, PCSrcE, StallF, StallD, FlushD;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pcf, w_instr, w_pcd, w_pcp4;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    // Second instance with a top-of-memory reset PC; handshake timing does
    // not depend on the address, so it shares the memory responses.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(w_pcf),
        .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pcp4), .ValidD(w_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder: rdata = granted address ----------
    int          gnt_lat = 1;
    int          rv_lat  = 0;
    bit          rnd_mem = 1'b0;
    bit          pend    = 1'b0;
    int          req_age = 0;
    int          resp_age = 0;
    logic        req_seen = 1'b0;
    logic [31:0] addr_seen = 32'h0;
    logic [31:0] resp_addr = 32'h0;

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_rvalid) pend = 1'b0;
            else if (pend) resp_age++;
            if (req_seen && imem_gnt) begin
                pend = 1'b1; resp_addr = addr_seen; resp_age = 0; req_age = 0;
                if (rnd_mem) begin
                    rv_lat  = $urandom_range(0, 3);
                    gnt_lat = $urandom_range(0, 3);
                end
            end else if (req_seen) req_age++;
            else req_age = 0;
            req_seen    = imem_req;
            addr_seen   = imem_addr;
            imem_gnt    = imem_req && (req_age >= gnt_lat);
            imem_rvalid = pend && (resp_age >= rv_lat);
            imem_rdata  = imem_rvalid ? resp_addr : $urandom();
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP_INSTR);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcp4", PCPlus4D, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_wrap_pcf", w_pcf, 32'hFFFF_FFFC);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ValidD) begin seen = 1'b1; break; end
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wait_state(input string name, input int budget);
        bit had_req = 1'b0;
        bit seen    = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (had_req && !imem_req) begin seen = 1'b1; break; end
            if (imem_req) had_req = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        sd, fd, br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epcd;
        logic        ci;
        logic [31:0] einstr;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic sd, input logic fd, input logic br, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epcd, input logic ci,
                       input logic [31:0] einstr, input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.sd = sd; v.fd = fd; v.br = br; v.tgt = tgt; v.ev = ev; v.epcd = epcd;
        v.ci = ci; v.einstr = einstr; v.ereq = ereq; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    // ---------------- random-run model state ----------------
    logic [31:0] exp_pc;
    logic        p_sd, p_br, p_req, p_gnt;
    logic [31:0] p_tgt, p_addr, rnd;
    int          ndeliv;

    initial begin
        // gnt one cycle after req, rvalid one cycle after gnt: 3 cycles/instr
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h0);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h0);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h0);
        add(0,0,0,32'h0,   1,32'h0,   1,32'h0,   1,32'h4);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h4);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h4);
        add(0,0,0,32'h0,   1,32'h4,   1,32'h4,   1,32'h8);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h8);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h8);
        add(0,0,1,32'h100, 0,32'h0,   0,32'h0,   1,32'h100);  // redirect, 0x8 dropped
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h100);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h100);
        add(0,0,0,32'h0,   1,32'h100, 1,32'h100, 1,32'h104);
        add(1,0,0,32'h0,   1,32'h100, 1,32'h100, 1,32'h104);  // StallD run
        add(1,0,0,32'h0,   1,32'h100, 1,32'h100, 0,32'h104);
        add(1,0,0,32'h0,   1,32'h100, 1,32'h100, 0,32'h104);  // rvalid -> hold
        add(1,0,0,32'h0,   1,32'h100, 1,32'h100, 0,32'h104);
        add(1,0,0,32'h0,   1,32'h100, 1,32'h100, 0,32'h104);
        add(0,0,0,32'h0,   1,32'h104, 1,32'h104, 1,32'h108);  // from skid, no refetch
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h108);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h108);
        add(0,1,0,32'h0,   0,32'h0,   1,32'h13,  1,32'h10C);  // flush with rvalid
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   1,32'h10C);
        add(0,0,0,32'h0,   0,32'h0,   0,32'h0,   0,32'h10C);
        add(0,0,0,32'h0,   1,32'h10C, 1,32'h10C, 1,32'h110);

        gnt_lat = 1; rv_lat = 0; rnd_mem = 1'b0;
        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            StallD = vq[i].sd; FlushD = vq[i].fd; PCSrcE = vq[i].br; PCTargetE = vq[i].tgt;
            @(negedge clk);
            chk($sformatf("tab%0d_valid", i), {31'b0, ValidD}, {31'b0, vq[i].ev});
            chk($sformatf("tab%0d_req", i), {31'b0, imem_req}, {31'b0, vq[i].ereq});
            chk($sformatf("tab%0d_addr", i), imem_addr, vq[i].eaddr);
            if (vq[i].ev) begin
                chk($sformatf("tab%0d_pcd", i), PCD, vq[i].epcd);
                chk($sformatf("tab%0d_pcp4", i), PCPlus4D, vq[i].epcd + 32'd4);
            end
            if (vq[i].ci) chk($sformatf("tab%0d_instr", i), InstrD, vq[i].einstr);
            if (i == 3) begin
                chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
                chk("wrap_pcp4", w_pcp4, 32'h0);
                chk("wrap_next_addr", w_addr, 32'h0);
            end
        end
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;

        // Redirect while a fetch is outstanding: kill path
        gnt_lat = 1; rv_lat = 3;
        do_reset();
        wait_wait_state("kill_wait", 10);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        @(negedge clk);
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        chk("kill_req_low", {31'b0, imem_req}, 32'd0);
        chk("kill_pcf", PCF, 32'h200);
        wait_valid("kill", 30);
        chk("kill_pcd", PCD, 32'h200);
        chk("kill_instr", InstrD, 32'h200);

        // Grant withheld: request and address held steady
        gnt_lat = 5; rv_lat = 0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("nognt%0d_req", k), {31'b0, imem_req}, 32'd1);
            chk($sformatf("nognt%0d_addr", k), imem_addr, 32'h0);
            @(negedge clk);
        end

        // Reset during S_WAIT with a stray rvalid afterwards
        gnt_lat = 1; rv_lat = 4;
        do_reset();
        wait_valid("stray_first", 30);
        wait_wait_state("stray_wait", 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, ValidD}, 32'd0);
        chk("midrst_pcf", PCF, 32'h0);
        rst_n = 1'b1; rv_lat = 0;
        wait_valid("stray_after", 30);
        chk("stray_pcd", PCD, 32'h0);
        chk("stray_instr", InstrD, 32'h0);

        // Randomized run against a stream-level model
        gnt_lat = 1; rv_lat = 1; rnd_mem = 1'b1;
        do_reset();
        exp_pc = 32'h0; ndeliv = 0;
        p_sd = 1'b0; p_br = 1'b0; p_tgt = 32'h0; p_req = 1'b0; p_gnt = 1'b0; p_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            StallD = ($urandom_range(0, 9) < 3);
            StallF = ($urandom_range(0, 9) < 2);
            PCSrcE = ($urandom_range(0, 39) == 0);
            rnd    = $urandom();
            PCTargetE = PCSrcE ? {rnd[31:2], 2'b00} : 32'h0;
            p_sd = StallD; p_br = PCSrcE; p_tgt = PCTargetE;
            p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
            @(negedge clk);
            chk("rnd_addr_is_pcf", imem_addr, PCF);
            if (p_req && !p_gnt && !p_br) chk("rnd_addr_hold", imem_addr, p_addr);
            if (p_br) begin
                if (!p_sd) chk("rnd_no_load_on_redirect", {31'b0, ValidD}, 32'd0);
                exp_pc = p_tgt;
            end else if (!p_sd && ValidD) begin
                chk("rnd_pcd", PCD, exp_pc);
                chk("rnd_instr", InstrD, exp_pc);
                chk("rnd_pcp4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end
        end
        chk("rnd_progress", {31'b0, ndeliv > 150}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
